// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch-stage program counter.
// Contents:
//   pc_state_t           - PC sequencer states (RUN / HALT)
//   RESET_VECTOR_DEFAULT - default PC after reset
//   TRAP_VECTOR_DEFAULT  - default PC after a trap
package cpu_pkg;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_HALT = 1'b1
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack.
// When full, a push overwrites the oldest entry and the count stays saturated.
// Callers must only assert i_pop or i_replace while the stack is non-empty.
// Ports:
//   i_clock, i_reset   - clock, asynchronous active-high reset
//   i_push             - push i_push_data as the new top
//   i_pop              - drop the top entry
//   i_replace          - overwrite the top entry with i_push_data
//   i_push_data        - data for push / replace
//   o_top_data         - current top entry
//   o_count            - number of valid entries (0..DEPTH)
//   o_full, o_empty    - occupancy status
module return_address_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_replace,
  input  logic [WIDTH-1:0]         i_push_data,
  output logic [WIDTH-1:0]         o_top_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_next_top;

  assign w_next_top = r_top + PTR_W'(1);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_top_data = r_mem[r_top];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from the same pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      // Pointer wraps naturally; when full this lands on the oldest entry.
      r_top <= w_next_top;
      if (!o_full) r_count <= r_count + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_top   <= r_top - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read once
  // the count says they are valid, so clearing them would be wasted logic.
  always_ff @(posedge i_clock) begin
    if (i_push) begin
      r_mem[w_next_top] <= i_push_data;
    end else if (i_replace && !o_empty) begin
      r_mem[r_top] <= i_push_data;
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with stall, sticky halt, trap wake-up and a
// return-address stack for call/return redirection.
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   is_halt               - enter HALT (unless trap in the same cycle)
//   stall                 - hold PC and RAS this cycle (RUN only)
//   trap                  - redirect to TRAP_VECTOR, leaves HALT
//   branch_taken          - redirect to branch_target
//   branch_target         - redirect / fallback address
//   is_call               - branch_taken is a call (push return address)
//   is_return             - redirect to RAS top and pop
//   program_counter_value - current PC (registered)
//   halted                - 1 while in HALT
//   ras_count             - valid RAS entries
//   ras_overflow          - sticky: call pushed while RAS full
//   ras_underflow         - sticky: return while RAS empty
module pc_unit_ras
  import cpu_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = RESET_VECTOR_DEFAULT[PC_WIDTH-1:0],
  parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = TRAP_VECTOR_DEFAULT[PC_WIDTH-1:0],
  parameter int unsigned          INSTR_BYTES  = 4,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        is_halt,
  input  logic                        stall,
  input  logic                        trap,
  input  logic                        branch_taken,
  input  logic [PC_WIDTH-1:0]         branch_target,
  input  logic                        is_call,
  input  logic                        is_return,
  output logic [PC_WIDTH-1:0]         program_counter_value,
  output logic                        halted,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow,
  output logic                        ras_underflow
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INSTR_BYTES);

  pc_state_t           r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_halted;
  logic                r_overflow;
  logic                r_underflow;

  logic [PC_WIDTH-1:0] w_ret_addr;
  logic [PC_WIDTH-1:0] w_ras_top;
  logic                w_ras_full;
  logic                w_ras_empty;
  logic                w_active;
  logic                w_swap;
  logic                w_push;
  logic                w_pop;
  logic                w_replace;

  // Wraps modulo 2^PC_WIDTH by construction.
  assign w_ret_addr = r_pc + STEP;

  // A cycle that reaches the return/branch levels of the priority chain.
  assign w_active = (r_state == PC_RUN) && !trap && !is_halt && !stall;
  assign w_swap   = is_return && is_call && branch_taken;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_replace = 1'b0;
    if (w_active) begin
      if (is_return) begin
        if (w_swap) begin
          // Co-routine swap; on an empty stack it degrades to a plain call.
          if (w_ras_empty) w_push    = 1'b1;
          else             w_replace = 1'b1;
        end else if (!w_ras_empty) begin
          w_pop = 1'b1;
        end
      end else if (branch_taken && is_call) begin
        w_push = 1'b1;
      end
    end
  end

  return_address_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_replace   (w_replace),
    .i_push_data (w_ret_addr),
    .o_top_data  (w_ras_top),
    .o_count     (ras_count),
    .o_full      (w_ras_full),
    .o_empty     (w_ras_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= PC_RUN;
      r_pc        <= RESET_VECTOR;
      r_halted    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        PC_HALT: begin
          if (trap) begin
            r_state  <= PC_RUN;
            r_halted <= 1'b0;
            r_pc     <= TRAP_VECTOR;
          end
        end
        PC_RUN: begin
          if (trap) begin
            r_pc <= TRAP_VECTOR;
          end else if (is_halt) begin
            r_state  <= PC_HALT;
            r_halted <= 1'b1;
          end else if (stall) begin
            r_pc <= r_pc;
          end else if (is_return) begin
            // Empty stack: fall back to branch_target (also covers empty swap).
            if (w_ras_empty) begin
              r_pc        <= branch_target;
              r_underflow <= 1'b1;
            end else begin
              r_pc <= w_ras_top;
            end
          end else if (branch_taken) begin
            r_pc <= branch_target;
            if (is_call && w_ras_full) r_overflow <= 1'b1;
          end else begin
            r_pc <= w_ret_addr;
          end
        end
        default: begin
          r_state  <= PC_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign program_counter_value = r_pc;
  assign halted                = r_halted;
  assign ras_overflow          = r_overflow;
  assign ras_underflow         = r_underflow;

endmodule
